// File: rtl/clkdiv_monitor.sv
// Measures period/high time of a divided clock sampled in the clock domain and tracks ratio lock.
// Results register one cycle after rise detection; no backpressure, purely observational.
module clkdiv_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             duty_ok,
  output logic             locked,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       LOCK_M  = 4'(LOCK_CNT);

  state_t           state;
  logic             d_q;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] ref_period;
  logic [3:0]       match;

  logic rise;
  logic fall;
  logic sat;
  logic same;
  logic capture;

  assign rise    = div_in & ~d_q;
  assign fall    = ~div_in & d_q;
  // A rise on the saturating cycle is still a rise; saturation only fires without one.
  assign sat     = (pcnt == CNT_MAX) && !rise;
  assign same    = (pcnt == ref_period);
  assign capture = rise && (state != IDLE) && !clear;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_q       <= 1'b0;
      pcnt      <= '0;
      hcnt      <= '0;
      high_time <= '0;
    end else begin
      d_q <= div_in;
      if (rise)
        pcnt <= CNT_ONE;
      else if (pcnt != CNT_MAX)
        pcnt <= pcnt + CNT_ONE;
      if (rise)
        hcnt <= CNT_ONE;
      else if (div_in && (hcnt != CNT_MAX))
        hcnt <= hcnt + CNT_ONE;
      if (fall)
        high_time <= hcnt;
    end
  end

  // high_time still holds the previous high phase here, which belongs to the period just closed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period       <= '0;
      period_valid <= 1'b0;
      duty_ok      <= 1'b0;
    end else begin
      period_valid <= capture;
      if (capture) begin
        period  <= pcnt;
        duty_ok <= ({high_time, 1'b0} == {1'b0, pcnt});
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ref_period <= '0;
      match      <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else if (clear) begin
      state  <= IDLE;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise)
            state <= ARM;
        end
        ARM: begin
          if (rise) begin
            ref_period <= pcnt;
            match      <= 4'd1;
            state      <= TRACK;
          end else if (sat) begin
            state <= IDLE;
          end
        end
        TRACK: begin
          if (rise) begin
            if (same) begin
              if (match == LOCK_M) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                match <= match + 4'd1;
              end
            end else begin
              ref_period <= pcnt;
              match      <= 4'd1;
            end
          end else if (sat) begin
            state <= IDLE;
          end
        end
        LOCKED: begin
          if (rise) begin
            if (!same) begin
              err        <= 1'b1;
              locked     <= 1'b0;
              ref_period <= pcnt;
              match      <= 4'd1;
              state      <= TRACK;
            end
          end else if (sat) begin
            err    <= 1'b1;
            locked <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
